fibonacci_stream: RTL and testbench

Parametrised Fibonacci sequence generator: loads two programmable seeds, emits a requested number of terms over a valid/ready stream, and detects arithmetic overflow. It generalises the fixed 4-bit free-running Fibonacci counter with configurable width, term count, back-pressure, start/done control and overflow reporting. It sits as a stimulus or number source feeding any stream consumer in the design.

---
 rtl/fibonacci_stream.sv | 143 ++++++++++++++
 tb/tb_fibonacci_stream.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fibonacci_stream.sv
// fibonacci_stream: programmable-seed Fibonacci generator with a valid/ready
// output stream, start/done control and a sticky overflow flag.
//
// Build option: define FIB_WRAP_EN to restart emission from the held seeds
// when the next term would overflow. Left undefined, an overflow ends the
// sequence early with ovf set.
module fibonacci_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // a is the term on the stream, b the one after it; b_ovf marks b as the
  // truncated result of a sum that carried out of WIDTH bits.
  logic [WIDTH-1:0] a, b;
  logic [CNT_W-1:0] rem;
  logic             b_ovf;
  logic             ovf_q;
`ifdef FIB_WRAP_EN
  logic [WIDTH-1:0] seed0_q, seed1_q;
`endif

  logic [WIDTH:0] sum;
  logic           accept;
  logic           handshake;
  logic           last_term;
  logic           ovf_hit;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign accept    = (state == IDLE) && start;
  assign handshake = (state == RUN) && out_ready;
  // Count exhaustion wins over overflow: the final requested term is emitted
  // even if its successor could not be represented.
  assign last_term = handshake && (rem == CNT_W'(1));
  assign ovf_hit   = handshake && !last_term && b_ovf;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (num_terms == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_term) begin
          state_nxt = DONE;
        end else if (ovf_hit) begin
`ifdef FIB_WRAP_EN
          state_nxt = RUN;
`else
          state_nxt = DONE;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: seed capture, term advance on handshake, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      rem   <= '0;
      b_ovf <= 1'b0;
      ovf_q <= 1'b0;
`ifdef FIB_WRAP_EN
      seed0_q <= '0;
      seed1_q <= '0;
`endif
    end else if (accept) begin
      a     <= seed0;
      b     <= seed1;
      rem   <= num_terms;
      b_ovf <= 1'b0;
      ovf_q <= 1'b0;
`ifdef FIB_WRAP_EN
      seed0_q <= seed0;
      seed1_q <= seed1;
`endif
    end else if (handshake) begin
      rem <= rem - CNT_W'(1);
      if (ovf_hit) ovf_q <= 1'b1;
`ifdef FIB_WRAP_EN
      if (ovf_hit) begin
        a     <= seed0_q;
        b     <= seed1_q;
        b_ovf <= 1'b0;
      end else begin
        a     <= b;
        b     <= sum[WIDTH-1:0];
        b_ovf <= sum[WIDTH];
      end
`else
      a     <= b;
      b     <= sum[WIDTH-1:0];
      b_ovf <= sum[WIDTH];
`endif
    end
  end

  // Outputs decoded from the state.
  always_comb begin
    out_valid = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    out_data  = (state == RUN) ? a : '0;
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_fibonacci_stream.sv
// tb_fibonacci_stream: directed checks of fibonacci_stream (WIDTH=16) with
// hand-computed term tables, back-pressure, start poking and mid-run reset.
module tb_fibonacci_stream;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] seed0, seed1;
  logic [CNT_W-1:0] num_terms;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_terms[$];

  fibonacci_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed0     (seed0),
    .seed1     (seed1),
    .num_terms (num_terms),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Starts a sequence and consumes it with out_ready following pat (bit 0
  // first, repeating every 4 cycles). Every accepted term is compared with
  // exp_terms; the term count and ovf are checked at done.
  task automatic run_seq(input string name, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [7:0] n, input logic [3:0] pat, input bit poke,
                         input logic exp_ovf);
    int          got  = 0;
    int          cyc  = 0;
    bit          fin  = 1'b0;
    bit          hold = 1'b0;
    logic [15:0] held = '0;
    @(negedge clk);
    seed0 = s0; seed1 = s1; num_terms = n; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // Changing the inputs after acceptance must not affect the sequence.
    seed0 = ~s0; seed1 = ~s1; num_terms = 8'd1;
    if (n == 0) begin
      check({name, "_zero_done"}, done, 1'b1);
    end else begin
      check({name, "_first_valid"}, out_valid, 1'b1);
      check({name, "_first_busy"}, busy, 1'b1);
      check({name, "_first_term"}, out_data, s0);
    end
    while (!fin && cyc < 200) begin
      if (done) begin
        start = 1'b0;
        check({name, "_count"}, got, exp_terms.size());
        check({name, "_ovf"}, ovf, exp_ovf);
        check({name, "_done_valid"}, out_valid, 1'b0);
        fin = 1'b1;
      end else begin
        check({name, "_valid"}, out_valid, 1'b1);
        if (hold) check({name, "_stable"}, out_data, held);
        out_ready = pat[cyc[1:0]];
        if (out_ready) begin
          if (got < exp_terms.size()) check($sformatf("%s_term%0d", name, got), out_data, exp_terms[got]);
          else                        check({name, "_extra_term"}, 1'b1, 1'b0);
          got++;
          hold = 1'b0;
        end else begin
          held = out_data;
          hold = 1'b1;
        end
        start = poke && (cyc % 3 == 1);
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) check({name, "_timeout"}, 1'b1, 1'b0);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_sticky_ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; num_terms = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_data", out_data, 16'h0);
    rst = 1'b0;

    exp_terms = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
    run_seq("basic", 16'd0, 16'd1, 8'd5, 4'b1111, 1'b0, 1'b0);

    exp_terms = '{16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21};
    run_seq("backpr", 16'd2, 16'd3, 8'd6, 4'b1001, 1'b1, 1'b0);

`ifdef FIB_WRAP_EN
    exp_terms = '{16'h4000, 16'h6000, 16'hA000, 16'h4000, 16'h6000, 16'hA000,
                  16'h4000, 16'h6000, 16'hA000, 16'h4000};
`else
    exp_terms = '{16'h4000, 16'h6000, 16'hA000};
`endif
    run_seq("ovf", 16'h4000, 16'h6000, 8'd10, 4'b1111, 1'b0, 1'b1);

    // Overflowing successor of the final term: count wins, no ovf.
    exp_terms = '{16'h4000, 16'h6000, 16'hA000};
    run_seq("lastovf", 16'h4000, 16'h6000, 8'd3, 4'b1111, 1'b0, 1'b0);

`ifdef FIB_WRAP_EN
    exp_terms = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000};
`else
    exp_terms = '{16'h7FFF, 16'h8000, 16'hFFFF};
`endif
    run_seq("maxterm", 16'h7FFF, 16'h8000, 8'd5, 4'b0111, 1'b1, 1'b1);

    exp_terms = {};
    run_seq("zero", 16'd7, 16'd9, 8'd0, 4'b1111, 1'b0, 1'b0);

    // Reset while running: abandon the sequence without a done pulse.
    @(negedge clk);
    seed0 = 16'd0; seed1 = 16'd1; num_terms = 8'd10; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_term0", out_data, 16'd0);
    @(negedge clk);
    check("mid_term1", out_data, 16'd1);
    @(negedge clk);
    check("mid_term2", out_data, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    check("mid_rst_idle", {out_valid, busy, done}, 3'b000);

    exp_terms = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
    run_seq("after_rst", 16'd0, 16'd1, 8'd5, 4'b1111, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
